// File: rtl/sar_ctrl_mc.sv
// -----------------------------------------------------------------------------
// sar_ctrl_mc
//
// Multi-channel successive-approximation ADC sequencer. It drives the analog
// mux, the sample/hold switch and the capacitive DAC, and runs a binary search
// on the external comparator. Each finished conversion is presented on q/q_ch,
// together with a one-cycle eoc strobe.
//
// Handshake: soc is a level input that is sampled only in IDLE. A soc seen in
// IDLE (with abort low) starts one conversion, or a scan of all channels.
// soc is ignored while busy=1. eoc is a one-cycle strobe with no back-pressure.
// The consumer must capture q/q_ch on the cycle in which eoc is high, or at any
// later time before the next eoc.
//
// Parameters:
//   WIDTH         conversion resolution (>= 2)
//   CHANNELS      number of analog inputs (>= 1)
//   SAMPLE_CYCLES sample window length in clocks (>= 1)
//   CH_W          channel index width, max(1, clog2(CHANNELS))
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   soc, scan     start of conversion, and scan-mode select sampled with soc
//   ch_sel        channel for single mode (out-of-range values are clamped)
//   abort         synchronous abort back to IDLE
//   cmp           comparator output (1 = input >= DAC)
//   dac           DAC trial code (0 outside CONV)
//   sample        S/H switch enable
//   mux_ch        analog mux select
//   q, q_ch       last completed result and its channel
//   eoc           one-cycle strobe marking a new q
//   busy          high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module sar_ctrl_mc #(
    parameter int WIDTH         = 10,
    parameter int CHANNELS      = 4,
    parameter int SAMPLE_CYCLES = 2,
    parameter int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soc,
    input  logic             scan,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic             abort,
    input  logic             cmp,
    output logic [WIDTH-1:0] dac,
    output logic             sample,
    output logic [CH_W-1:0]  mux_ch,
    output logic [WIDTH-1:0] q,
    output logic [CH_W-1:0]  q_ch,
    output logic             eoc,
    output logic             busy
);

    // The sample counter runs from 0 to SAMPLE_CYCLES-1.
    localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [WIDTH-1:0] MASK_MSB = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_CONV   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] mask_q,   mask_d;
    logic [WIDTH-1:0] trial_q,  trial_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             scan_q,   scan_d;
    logic [CH_W-1:0]  mux_ch_q, mux_ch_d;
    logic [WIDTH-1:0] q_q,      q_d;
    logic [CH_W-1:0]  q_ch_q,   q_ch_d;

    logic [WIDTH-1:0] trial_next;
    logic [CH_W-1:0]  ch_clamped;

    always_comb begin
        // Single-mode channel, clamped to the last real channel.
        ch_clamped = ch_sel;
        if (int'(ch_sel) >= CHANNELS) begin
            ch_clamped = CH_LAST;
        end

        // The trial value includes this cycle's comparator decision.
        trial_next = cmp ? (trial_q | mask_q) : trial_q;
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        trial_d  = trial_q;
        cnt_d    = cnt_q;
        scan_d   = scan_q;
        mux_ch_d = mux_ch_q;
        q_d      = q_q;
        q_ch_d   = q_ch_q;

        if (abort) begin
            // Abort overrides everything and also blocks a start from IDLE.
            // The result registers are left as they are.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (soc) begin
                        scan_d   = scan;
                        mux_ch_d = scan ? '0 : ch_clamped;
                        cnt_d    = '0;
                        state_d  = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (cnt_q == CNT_LAST) begin
                        mask_d  = MASK_MSB;
                        trial_d = '0;
                        state_d = S_CONV;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_CONV: begin
                    trial_d = trial_next;
                    mask_d  = mask_q >> 1;
                    // The LSB trial is the last one; publish the result.
                    if (mask_q[0]) begin
                        q_d     = trial_next;
                        q_ch_d  = mux_ch_q;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (scan_q && (mux_ch_q != CH_LAST)) begin
                        mux_ch_d = mux_ch_q + 1'b1;
                        cnt_d    = '0;
                        state_d  = S_SAMPLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            trial_q  <= '0;
            cnt_q    <= '0;
            scan_q   <= 1'b0;
            mux_ch_q <= '0;
            q_q      <= '0;
            q_ch_q   <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            trial_q  <= trial_d;
            cnt_q    <= cnt_d;
            scan_q   <= scan_d;
            mux_ch_q <= mux_ch_d;
            q_q      <= q_d;
            q_ch_q   <= q_ch_d;
        end
    end

    // These outputs are decoded from registered state only, so the
    // asynchronous reset clears them at once.
    assign dac    = (state_q == S_CONV) ? (trial_q | mask_q) : '0;
    assign sample = (state_q == S_SAMPLE);
    assign eoc    = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);
    assign mux_ch = mux_ch_q;
    assign q      = q_q;
    assign q_ch   = q_ch_q;

endmodule
